// File: rtl/ppu_regs_pkg.sv
// Shared definitions for the CPU-facing PPU register file.
package ppu_regs_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned VADDR_W = 15;
  localparam int unsigned BUS_A_W = 14;
  localparam int unsigned OAM_A_W = 8;

  // CPU register indices $2000-$2007
  typedef enum logic [2:0] {
    REG_CTRL     = 3'd0,
    REG_MASK     = 3'd1,
    REG_STATUS   = 3'd2,
    REG_OAM_ADDR = 3'd3,
    REG_OAM_DATA = 3'd4,
    REG_SCROLL   = 3'd5,
    REG_ADDR     = 3'd6,
    REG_DATA     = 3'd7
  } reg_idx_e;

  // $2007 access sequencer
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RD_FETCH  = 2'd1,
    ST_WR_COMMIT = 2'd2
  } state_e;

  // Status flags reported in $2002[7:5]
  typedef struct packed {
    logic vblank;
    logic spr0;
    logic ovf;
  } status_t;

  localparam logic [BUS_A_W-1:0] PAL_BASE   = 14'h3F00;
  localparam logic [VADDR_W-1:0] INC_ACROSS = 15'd1;
  localparam logic [VADDR_W-1:0] INC_DOWN   = 15'd32;

  // VRAM address step after a $2007 access, selected by PPUCTRL[2]
  function automatic logic [VADDR_W-1:0] vaddr_inc(input logic [DATA_W-1:0] ctrl_r);
    return ctrl_r[2] ? INC_DOWN : INC_ACROSS;
  endfunction

endpackage

// File: rtl/ppu_regs.sv
// CPU-facing PPU register file: PPUCTRL/PPUMASK, loopy scroll registers,
// $2007 read buffer, OAM address/data port and vblank/NMI flag.
module ppu_regs
  import ppu_regs_pkg::*;
(
  input  logic               clock25,
  input  logic               reset_n,
  input  logic               ce,
  input  logic [2:0]         cpu_a,
  input  logic [DATA_W-1:0]  cpu_i,
  input  logic               cpu_rd,
  input  logic               cpu_wr,
  output logic [DATA_W-1:0]  cpu_o,
  output logic               nmi_n,
  input  logic               vblank_set,
  input  logic               vblank_clr,
  input  logic               spr0_hit,
  input  logic               spr_ovf,
  output logic [BUS_A_W-1:0] vram_a,
  input  logic [DATA_W-1:0]  vram_i,
  output logic [DATA_W-1:0]  vram_o,
  output logic               vram_w,
  output logic [OAM_A_W-1:0] oam_a,
  input  logic [DATA_W-1:0]  oam_i,
  output logic [DATA_W-1:0]  oam_o,
  output logic               oam_w,
  output logic [DATA_W-1:0]  ctrl,
  output logic [DATA_W-1:0]  mask,
  output logic [VADDR_W-1:0] scroll_t,
  output logic [2:0]         fine_x
);

  state_e             state, state_nxt;
  status_t            flags, flags_nxt;
  logic [DATA_W-1:0]  ctrl_nxt;
  logic [VADDR_W-1:0] v;
  logic               w;
  logic [DATA_W-1:0]  ob;
  logic [DATA_W-1:0]  rdbuf;

  logic     acc_c, wr_c, rd_c, status_rd_c, pal_c;
  reg_idx_e idx_c;

  assign idx_c       = reg_idx_e'(cpu_a);
  assign acc_c       = ce & (cpu_rd | cpu_wr) & (state == ST_IDLE);
  assign wr_c        = acc_c & cpu_wr;
  assign rd_c        = acc_c & ~cpu_wr;
  assign status_rd_c = rd_c & (idx_c == REG_STATUS);
  assign pal_c       = (v[BUS_A_W-1:0] >= PAL_BASE);
  assign vram_a      = v[BUS_A_W-1:0];

  // FSM state register
  always_ff @(posedge clock25 or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next state, next PPUCTRL and next status flags
  always_comb begin
    state_nxt = state;
    ctrl_nxt  = ctrl;
    flags_nxt = flags;
    case (state)
      ST_IDLE: begin
        if (wr_c && idx_c == REG_DATA)      state_nxt = ST_WR_COMMIT;
        else if (rd_c && idx_c == REG_DATA) state_nxt = ST_RD_FETCH;
      end
      ST_RD_FETCH:  state_nxt = ST_IDLE;
      ST_WR_COMMIT: state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
    if (wr_c && idx_c == REG_CTRL) ctrl_nxt = cpu_i;
    if (spr0_hit) flags_nxt.spr0 = 1'b1;
    if (spr_ovf)  flags_nxt.ovf  = 1'b1;
    // A status read racing the set pulse swallows the vblank (NMI suppression)
    if (vblank_set && !status_rd_c) flags_nxt.vblank = 1'b1;
    if (status_rd_c)                flags_nxt.vblank = 1'b0;
    if (vblank_clr)                 flags_nxt = '0;
  end

  // Register file datapath, bus strobes and CPU read data
  always_ff @(posedge clock25 or negedge reset_n) begin
    if (!reset_n) begin
      ctrl     <= '0;
      mask     <= '0;
      scroll_t <= '0;
      fine_x   <= '0;
      v        <= '0;
      w        <= 1'b0;
      ob       <= '0;
      rdbuf    <= '0;
      cpu_o    <= '0;
      oam_a    <= '0;
      oam_o    <= '0;
      oam_w    <= 1'b0;
      vram_o   <= '0;
      vram_w   <= 1'b0;
      flags    <= '0;
      nmi_n    <= 1'b1;
    end else begin
      vram_w <= 1'b0;
      oam_w  <= 1'b0;
      ctrl   <= ctrl_nxt;
      flags  <= flags_nxt;
      nmi_n  <= ~(flags_nxt.vblank & ctrl_nxt[7]);

      if (oam_w) oam_a <= oam_a + 8'd1;
      if (state == ST_RD_FETCH && !pal_c) rdbuf <= vram_i;
      if (state == ST_RD_FETCH || state == ST_WR_COMMIT) v <= v + vaddr_inc(ctrl);

      if (wr_c) begin
        ob <= cpu_i;
        case (idx_c)
          REG_CTRL:     scroll_t[11:10] <= cpu_i[1:0];
          REG_MASK:     mask <= cpu_i;
          REG_OAM_ADDR: oam_a <= cpu_i;
          REG_OAM_DATA: begin
            oam_o <= cpu_i;
            oam_w <= 1'b1;
          end
          REG_SCROLL: begin
            if (!w) begin
              fine_x        <= cpu_i[2:0];
              scroll_t[4:0] <= cpu_i[7:3];
              w             <= 1'b1;
            end else begin
              scroll_t[14:12] <= cpu_i[2:0];
              scroll_t[9:5]   <= cpu_i[7:3];
              w               <= 1'b0;
            end
          end
          REG_ADDR: begin
            if (!w) begin
              scroll_t[14:8] <= {1'b0, cpu_i[5:0]};
              w              <= 1'b1;
            end else begin
              scroll_t[7:0] <= cpu_i;
              v             <= {scroll_t[14:8], cpu_i};
              w             <= 1'b0;
            end
          end
          REG_DATA: begin
            vram_o <= cpu_i;
            vram_w <= 1'b1;
          end
          default: ;
        endcase
      end

      if (rd_c) begin
        case (idx_c)
          REG_STATUS: begin
            cpu_o <= {flags.vblank & ~vblank_set, flags.spr0, flags.ovf, ob[4:0]};
            w     <= 1'b0;
          end
          REG_OAM_DATA: cpu_o <= oam_i;
          REG_DATA:     cpu_o <= pal_c ? vram_i : rdbuf;
          default:      cpu_o <= ob;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ppu_regs.sv
// Directed bench for ppu_regs with a small VRAM/OAM bus model.
module tb_ppu_regs;
  import ppu_regs_pkg::*;

  logic        clock25, reset_n, ce, cpu_rd, cpu_wr;
  logic [2:0]  cpu_a;
  logic [7:0]  cpu_i, cpu_o;
  logic        nmi_n, vblank_set, vblank_clr, spr0_hit, spr_ovf;
  logic [13:0] vram_a;
  logic [7:0]  vram_i, vram_o, oam_a, oam_i, oam_o, ctrl, mask;
  logic        vram_w, oam_w;
  logic [14:0] scroll_t;
  logic [2:0]  fine_x;

  int vectors = 0;
  int errs    = 0;

  ppu_regs dut (
    .clock25(clock25), .reset_n(reset_n), .ce(ce), .cpu_a(cpu_a), .cpu_i(cpu_i),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_o(cpu_o), .nmi_n(nmi_n),
    .vblank_set(vblank_set), .vblank_clr(vblank_clr), .spr0_hit(spr0_hit),
    .spr_ovf(spr_ovf), .vram_a(vram_a), .vram_i(vram_i), .vram_o(vram_o),
    .vram_w(vram_w), .oam_a(oam_a), .oam_i(oam_i), .oam_o(oam_o), .oam_w(oam_w),
    .ctrl(ctrl), .mask(mask), .scroll_t(scroll_t), .fine_x(fine_x)
  );

  initial clock25 = 1'b0;
  always #20 clock25 = ~clock25;

  // VRAM contents seen by the register file
  always_comb begin
    case (vram_a)
      14'h2000: vram_i = 8'h11;
      14'h2020: vram_i = 8'h22;
      14'h3F00: vram_i = 8'h0F;
      default:  vram_i = 8'h00;
    endcase
  end

  assign oam_i = oam_a ^ 8'h5A;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One CPU access in cycle N; returns #1 after the edge ending N
  task automatic access(input logic wr, input logic [2:0] a, input logic [7:0] d);
    @(negedge clock25);
    ce = 1'b1; cpu_wr = wr; cpu_rd = ~wr; cpu_a = a; cpu_i = d;
    @(posedge clock25); #1;
    ce = 1'b0; cpu_wr = 1'b0; cpu_rd = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock25);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    access(1'b1, a, d);
    idle(2);
  endtask

  task automatic pulse(input logic vs, input logic vc, input logic sh, input logic so);
    @(negedge clock25);
    vblank_set = vs; vblank_clr = vc; spr0_hit = sh; spr_ovf = so;
    @(posedge clock25); #1;
    vblank_set = 1'b0; vblank_clr = 1'b0; spr0_hit = 1'b0; spr_ovf = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; ce = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_a = '0; cpu_i = '0;
    vblank_set = 1'b0; vblank_clr = 1'b0; spr0_hit = 1'b0; spr_ovf = 1'b0;
    #50;
    chk("rst_cpu_o", 32'(cpu_o), 32'h00);
    chk("rst_nmi_n", 32'(nmi_n), 32'h1);
    chk("rst_vram_a", 32'(vram_a), 32'h0);
    chk("rst_vram_w", 32'(vram_w), 32'h0);
    chk("rst_oam", 32'({oam_a, oam_w}), 32'h0);
    chk("rst_ctrl_mask", 32'({ctrl, mask}), 32'h0);
    chk("rst_scroll", 32'({scroll_t, fine_x}), 32'h0);
    @(negedge clock25); reset_n = 1'b1;
    idle(2);

    // $2007 writes with +1 increment
    wr(REG_ADDR, 8'h21); wr(REG_ADDR, 8'h08);
    chk("addr_v", 32'(vram_a), 32'h2108);
    access(1'b1, REG_DATA, 8'hAB);
    chk("w1_pulse", 32'(vram_w), 32'h1);
    chk("w1_addr", 32'(vram_a), 32'h2108);
    chk("w1_data", 32'(vram_o), 32'hAB);
    idle(1);
    chk("w1_end", 32'(vram_w), 32'h0);
    chk("w1_inc", 32'(vram_a), 32'h2109);
    idle(1);
    access(1'b1, REG_DATA, 8'hCD);
    chk("w2_pulse", 32'(vram_w), 32'h1);
    chk("w2_addr", 32'(vram_a), 32'h2109);
    chk("w2_data", 32'(vram_o), 32'hCD);
    idle(2);
    chk("w2_inc", 32'(vram_a), 32'h210A);

    // Buffered $2007 reads with +32 increment
    wr(REG_CTRL, 8'h04);
    chk("ctrl_04", 32'(ctrl), 32'h04);
    wr(REG_ADDR, 8'h20); wr(REG_ADDR, 8'h00);
    access(1'b0, REG_DATA, 8'h00);
    chk("rd1_stale", 32'(cpu_o), 32'h00);
    idle(2);
    chk("rd1_inc", 32'(vram_a), 32'h2020);
    access(1'b0, REG_DATA, 8'h00);
    chk("rd2_buf", 32'(cpu_o), 32'h11);
    idle(2);
    chk("rd2_inc", 32'(vram_a), 32'h2040);

    // Palette read bypasses and preserves the buffer (holding 22)
    wr(REG_ADDR, 8'h3F); wr(REG_ADDR, 8'h00);
    access(1'b0, REG_DATA, 8'h00);
    chk("pal_rd", 32'(cpu_o), 32'h0F);
    idle(2);
    chk("pal_inc", 32'(vram_a), 32'h3F20);
    wr(REG_ADDR, 8'h20); wr(REG_ADDR, 8'h40);
    access(1'b0, REG_DATA, 8'h00);
    chk("pal_buf_kept", 32'(cpu_o), 32'h22);
    idle(2);

    // Scroll writes and w toggle reset by $2002
    wr(REG_SCROLL, 8'h7D);
    chk("scr_fx", 32'(fine_x), 32'h5);
    wr(REG_SCROLL, 8'h5E);
    chk("scr_t", 32'(scroll_t), 32'h616F);
    wr(REG_SCROLL, 8'h7D);
    access(1'b0, REG_STATUS, 8'h00);
    chk("stat_ob", 32'(cpu_o), 32'h1D);
    idle(2);
    wr(REG_SCROLL, 8'h13);
    chk("scr_w_rst_fx", 32'(fine_x), 32'h3);
    chk("scr_w_rst_t", 32'(scroll_t), 32'h6162);
    wr(REG_SCROLL, 8'h00);
    chk("scr_second", 32'(scroll_t), 32'h0002);

    // PPUMASK and open-bus read
    wr(REG_MASK, 8'h1E);
    chk("mask", 32'(mask), 32'h1E);
    access(1'b0, REG_CTRL, 8'h00);
    chk("open_bus", 32'(cpu_o), 32'h1E);
    idle(2);

    // vblank / NMI
    wr(REG_CTRL, 8'h80);
    chk("nmi_idle", 32'(nmi_n), 32'h1);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    chk("nmi_set", 32'(nmi_n), 32'h0);
    access(1'b0, REG_STATUS, 8'h00);
    chk("stat_vbl", 32'(cpu_o), 32'h80);
    chk("nmi_ack", 32'(nmi_n), 32'h1);
    idle(2);
    @(negedge clock25);
    ce = 1'b1; cpu_rd = 1'b1; cpu_a = REG_STATUS; vblank_set = 1'b1;
    @(posedge clock25); #1;
    ce = 1'b0; cpu_rd = 1'b0; vblank_set = 1'b0;
    chk("race_bit7", 32'(cpu_o), 32'h00);
    idle(2);
    chk("race_no_nmi", 32'(nmi_n), 32'h1);
    wr(REG_CTRL, 8'h00);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    chk("nmi_masked", 32'(nmi_n), 32'h1);
    access(1'b1, REG_CTRL, 8'h80);
    chk("nmi_ctrl_late", 32'(nmi_n), 32'h0);
    idle(2);
    pulse(1'b0, 1'b0, 1'b1, 1'b1);
    access(1'b0, REG_STATUS, 8'h00);
    chk("stat_all", 32'(cpu_o), 32'hE0);
    idle(2);
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    chk("clr_wins_nmi", 32'(nmi_n), 32'h1);
    access(1'b0, REG_STATUS, 8'h00);
    chk("clr_wins_stat", 32'(cpu_o), 32'h00);
    idle(2);

    // OAM write with address wrap, then OAM read
    wr(REG_OAM_ADDR, 8'hFF);
    chk("oam_addr", 32'(oam_a), 32'hFF);
    access(1'b1, REG_OAM_DATA, 8'hAA);
    chk("oam_pulse", 32'({oam_w, oam_a, oam_o}), 32'h1FFAA);
    idle(1);
    chk("oam_wrap", 32'({oam_w, oam_a}), 32'h000);
    idle(1);
    access(1'b0, REG_OAM_DATA, 8'h00);
    chk("oam_rd", 32'(cpu_o), 32'h5A);
    chk("oam_rd_addr", 32'(oam_a), 32'h00);
    idle(2);

    // Reset during WR_COMMIT aborts the write
    wr(REG_ADDR, 8'h21); wr(REG_ADDR, 8'h08);
    access(1'b1, REG_DATA, 8'h77);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_vram_w", 32'(vram_w), 32'h0);
    chk("abort_vram_a", 32'(vram_a), 32'h0);
    chk("abort_regs", 32'({ctrl, cpu_o, oam_a}), 32'h0);
    chk("abort_nmi", 32'(nmi_n), 32'h1);
    chk("abort_scroll", 32'({scroll_t, fine_x}), 32'h0);
    idle(1);
    @(negedge clock25); reset_n = 1'b1;
    idle(3);
    chk("abort_no_inc", 32'({vram_w, vram_a}), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
